// File: rtl/uart_ctrl_pkg.sv
// Shared types and widths for the UART control slice: arbiter FSM states,
// byte width and timeout counter width.
package uart_ctrl_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned TO_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    SEND
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester and transmitter handshake bundle for uart_tx_arbiter.
// The master modport is the arbiter; slave is the requester/transmitter side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_ctrl_pkg::*;

  logic [NUM_REQ-1:0]        req;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        done;
  logic [NUM_REQ-1:0]        err;
  logic [BYTE_W-1:0]         d_in;
  logic                      tx_send;
  logic                      enable_tx;
  logic                      tx_sending;
  logic                      busy;

  modport master (
    input  req, req_data, tx_sending,
    output grant, done, err, d_in, tx_send, enable_tx, busy
  );

  modport slave (
    output req, req_data, tx_sending,
    input  grant, done, err, d_in, tx_send, enable_tx, busy
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr,
// wrapping modulo NUM_REQ. Returns one-hot winner, its index and a valid flag.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [PTR_W-1:0]   win_idx,
  output logic               win_valid
);

  logic [PTR_W-1:0] cand;

  always_comb begin
    win_oh    = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((32'(ptr) + i) % 32'(NUM_REQ));
      if (!win_valid && req[cand]) begin
        win_valid    = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one uart_tx among NUM_REQ byte producers.
// Optional START timeout abort enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int TIMEOUT_TICKS = 32
) (
  input  logic              clock,
  input  logic              reset_uart,
  input  logic              enable_uart,
  uart_tx_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(NUM_REQ);

  arb_state_e         state;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   cur_idx;
  logic [PTR_W-1:0]   next_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [PTR_W-1:0]   win_idx;
  logic               win_valid;
  logic [BYTE_W-1:0]  lane [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_lane
    assign lane[g] = bus.req_data[g*BYTE_W +: BYTE_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req       (bus.req),
    .ptr       (ptr),
    .win_oh    (win_oh),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  assign next_ptr = (32'(cur_idx) == 32'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;
  assign bus.busy = (state != IDLE);

`ifdef UART_ARB_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] TO_LIMIT = TO_CNT_W'(TIMEOUT_TICKS);
  logic [TO_CNT_W-1:0] to_cnt;
`else
  logic unused_cfg;
  assign unused_cfg = enable_uart & (TIMEOUT_TICKS != 0);
`endif

  always_ff @(posedge clock or negedge reset_uart) begin
    if (!reset_uart) begin
      state         <= IDLE;
      ptr           <= '0;
      cur_idx       <= '0;
      bus.grant     <= '0;
      bus.done      <= '0;
      bus.err       <= '0;
      bus.d_in      <= '0;
      bus.tx_send   <= 1'b0;
      bus.enable_tx <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
      to_cnt        <= '0;
`endif
    end else begin
      bus.enable_tx <= 1'b1;
      bus.done      <= '0;
      bus.err       <= '0;
      unique case (state)
        IDLE: begin
          if (win_valid) begin
            bus.grant <= win_oh;
            bus.d_in  <= lane[win_idx];
            cur_idx   <= win_idx;
            state     <= START;
`ifdef UART_ARB_TIMEOUT_EN
            to_cnt    <= '0;
`endif
          end
        end
        // tx_send rises one cycle after grant; a tx_sending already high
        // here is taken as the ack.
        START: begin
          if (bus.tx_sending) begin
            bus.tx_send <= 1'b0;
            state       <= SEND;
          end
`ifdef UART_ARB_TIMEOUT_EN
          else if (enable_uart && (to_cnt + 1'b1 == TO_LIMIT)) begin
            bus.tx_send      <= 1'b0;
            bus.grant        <= '0;
            bus.err[cur_idx] <= 1'b1;
            ptr              <= next_ptr;
            state            <= IDLE;
          end else begin
            bus.tx_send <= 1'b1;
            if (enable_uart) begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
`else
          else begin
            bus.tx_send <= 1'b1;
          end
`endif
        end
        SEND: begin
          if (!bus.tx_sending) begin
            bus.done[cur_idx] <= 1'b1;
            bus.grant         <= '0;
            ptr               <= next_ptr;
            state             <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter with a behavioural
// uart_tx sending-flag model and a periodic enable_uart tick.
module tb_uart_tx_arbiter;
  import uart_ctrl_pkg::*;

  localparam int NUM_REQ = 4;

  logic clock = 1'b0;
  logic reset_uart;
  logic enable_uart;

  always #5 clock = ~clock;

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ       (NUM_REQ),
    .TIMEOUT_TICKS (4)
  ) dut (
    .clock       (clock),
    .reset_uart  (reset_uart),
    .enable_uart (enable_uart),
    .bus         (bus)
  );

  int checks = 0;
  int passes = 0;
  bit model_en = 1'b0;
  int hold_len = 8;

  // uart_tx stand-in: tx_sending rises 3 clocks after tx_send, holds hold_len clocks
  initial begin
    int phase;
    int cnt;
    phase = 0;
    cnt   = 0;
    bus.tx_sending = 1'b0;
    forever begin
      @(negedge clock);
      if (!model_en || reset_uart !== 1'b1) begin
        bus.tx_sending = 1'b0;
        phase = 0;
        cnt   = 0;
      end else begin
        case (phase)
          0: if (bus.tx_send) begin phase = 1; cnt = 0; end
          1: begin
            cnt++;
            if (cnt == 2) begin bus.tx_sending = 1'b1; phase = 2; cnt = 0; end
          end
          default: begin
            cnt++;
            if (cnt == hold_len) begin bus.tx_sending = 1'b0; phase = 0; end
          end
        endcase
      end
    end
  end

  // one-clock enable_uart every third clock
  initial begin
    int ecnt;
    ecnt = 0;
    enable_uart = 1'b0;
    forever begin
      @(negedge clock);
      ecnt = (ecnt == 2) ? 0 : ecnt + 1;
      enable_uart = (ecnt == 2);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wait_grant(input int budget, output bit ok, output int n);
    ok = 1'b0;
    n  = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      n++;
      if (bus.grant != '0) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      tick();
      if (bus.done != '0) ok = 1'b1;
    end
  endtask

  task automatic test_reset;
    reset_uart   = 1'b0;
    bus.req      = '0;
    bus.req_data = '0;
    model_en     = 1'b0;
    repeat (3) tick();
    checks++;
    if (bus.grant !== 4'b0000) $display("FAIL rst_grant: got %b want 0000", bus.grant);
    else passes++;
    checks++;
    if (bus.d_in !== 8'h00) $display("FAIL rst_d_in: got %h want 00", bus.d_in);
    else passes++;
    checks++;
    if ({bus.tx_send, bus.enable_tx, bus.busy, bus.done, bus.err} !== 11'b0)
      $display("FAIL rst_ctrl: got %b want 0", {bus.tx_send, bus.enable_tx, bus.busy, bus.done, bus.err});
    else passes++;
    reset_uart = 1'b1;
    tick();
    checks++;
    if (bus.enable_tx !== 1'b1) $display("FAIL enable_tx: got %b want 1", bus.enable_tx);
    else passes++;
    repeat (3) tick();
    checks++;
    if ({bus.busy, bus.grant, bus.d_in} !== 13'b0)
      $display("FAIL idle_no_req: got %b want 0", {bus.busy, bus.grant, bus.d_in});
    else passes++;
  endtask

  task automatic test_single;
    bit seen_rise, got_done;
    logic prev_sending, prev_send;
    hold_len     = 160;
    model_en     = 1'b1;
    bus.req_data = {8'h44, 8'h33, 8'hA5, 8'h11};
    bus.req      = 4'b0010;
    tick();
    checks++;
    if (bus.grant !== 4'b0010 || bus.d_in !== 8'hA5)
      $display("FAIL single_grant: got %b/%h want 0010/a5", bus.grant, bus.d_in);
    else passes++;
    tick();
    checks++;
    if (bus.tx_send !== 1'b1) $display("FAIL single_tx_send: got %b want 1", bus.tx_send);
    else passes++;
    seen_rise    = 1'b0;
    got_done     = 1'b0;
    prev_sending = bus.tx_sending;
    prev_send    = bus.tx_send;
    for (int i = 0; i < 400 && !got_done; i++) begin
      tick();
      if (!seen_rise && bus.tx_sending === 1'b1) begin
        seen_rise = 1'b1;
        checks++;
        if ({prev_send, bus.tx_send} !== 2'b10)
          $display("FAIL send_drop: got %b want 10", {prev_send, bus.tx_send});
        else passes++;
      end
      if (bus.done != '0) begin
        got_done = 1'b1;
        checks++;
        if (bus.done !== 4'b0010) $display("FAIL single_done: got %b want 0010", bus.done);
        else passes++;
        checks++;
        if ({prev_sending, bus.tx_sending, bus.busy, bus.grant} !== 7'b1000000)
          $display("FAIL done_latency: got %b want 1000000",
                   {prev_sending, bus.tx_sending, bus.busy, bus.grant});
        else passes++;
      end
      prev_sending = bus.tx_sending;
      prev_send    = bus.tx_send;
    end
    checks++;
    if (got_done !== 1'b1) $display("FAIL single_done_seen: got %b want 1", got_done);
    else passes++;
    bus.req = '0;
    tick();
    checks++;
    if ({bus.done, bus.busy} !== 5'b0) $display("FAIL done_pulse_width: got %b want 0", {bus.done, bus.busy});
    else passes++;
  endtask

  task automatic test_round_robin;
    logic [7:0] lanes [4];
    bit ok;
    int n;
    lanes = '{8'h11, 8'h22, 8'h33, 8'h44};
    reset_uart = 1'b0;
    tick();
    hold_len     = 8;
    model_en     = 1'b1;
    bus.req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    bus.req      = 4'b1111;
    reset_uart   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      int e;
      e = k % 4;
      wait_grant(50, ok, n);
      checks++;
      if (!ok || bus.grant !== 4'(1 << e) || bus.d_in !== lanes[e])
        $display("FAIL rr_grant%0d: got %b/%h want %b/%h", k, bus.grant, bus.d_in, 4'(1 << e), lanes[e]);
      else passes++;
      if (k > 0) begin
        checks++;
        if (n !== 1) $display("FAIL rr_gap%0d: got %0d want 1", k, n);
        else passes++;
      end
      wait_done(200, ok);
      checks++;
      if (!ok || bus.done !== 4'(1 << e))
        $display("FAIL rr_done%0d: got %b want %b", k, bus.done, 4'(1 << e));
      else passes++;
    end
    bus.req = '0;
    tick();
  endtask

  task automatic test_drop_req;
    bit ok;
    int n;
    bus.req_data = {8'h44, 8'h5C, 8'h22, 8'h11};
    bus.req      = 4'b0100;
    wait_grant(20, ok, n);
    checks++;
    if (!ok || bus.grant !== 4'b0100 || bus.d_in !== 8'h5C)
      $display("FAIL drop_grant: got %b/%h want 0100/5c", bus.grant, bus.d_in);
    else passes++;
    tick();
    bus.req = '0;
    wait_done(200, ok);
    checks++;
    if (!ok || bus.done !== 4'b0100) $display("FAIL drop_done: got %b want 0100", bus.done);
    else passes++;
    tick();
  endtask

  task automatic test_reset_mid;
    bit ok, in_send;
    int n;
    hold_len     = 40;
    bus.req_data = {8'h77, 8'h33, 8'h22, 8'h9E};
    bus.req      = 4'b1000;
    wait_grant(20, ok, n);
    checks++;
    if (!ok || bus.grant !== 4'b1000) $display("FAIL mid_pre_grant: got %b want 1000", bus.grant);
    else passes++;
    in_send = 1'b0;
    for (int i = 0; i < 30 && !in_send; i++) begin
      tick();
      if (bus.tx_sending === 1'b1 && bus.tx_send === 1'b0 && bus.busy === 1'b1) in_send = 1'b1;
    end
    tick();
    bus.req    = 4'b1001;
    reset_uart = 1'b0;
    #1;
    checks++;
    if (!in_send || {bus.grant, bus.done, bus.err, bus.d_in, bus.tx_send, bus.enable_tx, bus.busy} !== 23'b0)
      $display("FAIL mid_reset_outputs: got %b want 0 (send reached %b)",
               {bus.grant, bus.done, bus.err, bus.d_in, bus.tx_send, bus.enable_tx, bus.busy}, in_send);
    else passes++;
    repeat (2) tick();
    reset_uart = 1'b1;
    wait_grant(20, ok, n);
    checks++;
    if (!ok || bus.grant !== 4'b0001 || bus.d_in !== 8'h9E)
      $display("FAIL mid_post_grant: got %b/%h want 0001/9e", bus.grant, bus.d_in);
    else passes++;
    bus.req = '0;
    wait_done(200, ok);
    checks++;
    if (!ok || bus.done !== 4'b0001) $display("FAIL mid_post_done: got %b want 0001", bus.done);
    else passes++;
    tick();
  endtask

`ifdef UART_ARB_TIMEOUT_EN
  task automatic test_timeout;
    bit ok, got_err, saw_done;
    int n, ticks;
    reset_uart = 1'b0;
    model_en   = 1'b0;
    bus.req    = 4'b0011;
    tick();
    reset_uart = 1'b1;
    wait_grant(20, ok, n);
    checks++;
    if (!ok || bus.grant !== 4'b0001) $display("FAIL to_grant0: got %b want 0001", bus.grant);
    else passes++;
    ticks    = 0;
    got_err  = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 100 && !got_err; i++) begin
      tick();
      if (enable_uart) ticks++;
      if (bus.done != '0) saw_done = 1'b1;
      if (bus.err != '0) got_err = 1'b1;
    end
    checks++;
    if (!got_err || bus.err !== 4'b0001 || ticks !== 4)
      $display("FAIL to_err: got %b after %0d ticks want 0001 after 4", bus.err, ticks);
    else passes++;
    checks++;
    if ({bus.tx_send, bus.grant, saw_done} !== 6'b0)
      $display("FAIL to_abort_outputs: got %b want 0", {bus.tx_send, bus.grant, saw_done});
    else passes++;
    tick();
    checks++;
    if (bus.grant !== 4'b0010 || bus.err !== 4'b0000)
      $display("FAIL to_next_grant: got %b err %b want 0010 err 0000", bus.grant, bus.err);
    else passes++;
    bus.req = '0;
    got_err = 1'b0;
    for (int i = 0; i < 100 && !got_err; i++) begin
      tick();
      if (bus.err != '0) got_err = 1'b1;
    end
    tick();
  endtask
`else
  task automatic test_timeout;
    bit ok, bad_send, bad_err;
    int n;
    reset_uart = 1'b0;
    model_en   = 1'b0;
    bus.req    = 4'b0011;
    tick();
    reset_uart = 1'b1;
    wait_grant(20, ok, n);
    checks++;
    if (!ok || bus.grant !== 4'b0001) $display("FAIL nto_grant: got %b want 0001", bus.grant);
    else passes++;
    tick();
    bad_send = 1'b0;
    bad_err  = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      tick();
      if (bus.tx_send !== 1'b1) bad_send = 1'b1;
      if (bus.err !== 4'b0000) bad_err = 1'b1;
    end
    checks++;
    if (bad_send !== 1'b0) $display("FAIL nto_tx_send_held: got dropped=%b want 0", bad_send);
    else passes++;
    checks++;
    if (bad_err !== 1'b0) $display("FAIL nto_err_zero: got seen=%b want 0", bad_err);
    else passes++;
    bus.req    = '0;
    reset_uart = 1'b0;
    tick();
    reset_uart = 1'b1;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_drop_req();
    test_reset_mid();
    test_timeout();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
